// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus bundle between the core, the ML coprocessor and the regfile.
// The arbiter owns the slave side; the driver of requests owns the master side.
interface regfile_wb_arbiter_if;
    logic        core_wb_valid;
    logic        core_wb_ready;
    logic [4:0]  core_wb_addr;
    logic [31:0] core_wb_data;

    logic        cop_wb_valid;
    logic        cop_wb_ready;
    logic [4:0]  cop_wb_addr;
    logic [31:0] cop_wb_data;

    logic        cop_issue_valid;
    logic [4:0]  cop_issue_addr;

    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        stall;

    logic        rf_w_enable;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic [31:0] busy_mask;

    modport master (
        output core_wb_valid, core_wb_addr, core_wb_data,
        input  core_wb_ready,
        output cop_wb_valid, cop_wb_addr, cop_wb_data,
        input  cop_wb_ready,
        output cop_issue_valid, cop_issue_addr,
        output rs1_addr, rs2_addr,
        input  stall,
        input  rf_w_enable, rf_rd_addr, rf_rd_data, busy_mask
    );

    modport slave (
        input  core_wb_valid, core_wb_addr, core_wb_data,
        output core_wb_ready,
        input  cop_wb_valid, cop_wb_addr, cop_wb_data,
        output cop_wb_ready,
        input  cop_issue_valid, cop_issue_addr,
        input  rs1_addr, rs2_addr,
        output stall,
        output rf_w_enable, rf_rd_addr, rf_rd_data, busy_mask
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Single-port regfile writeback arbiter: core-first with bounded coprocessor
// starvation, one-cycle write stage and a pending-write scoreboard for decode.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_q, starve_d;
    logic          wen_q, wen_d;
    logic [4:0]    waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   busy_q, busy_d;

    logic at_lim;
    logic core_rdy;
    logic cop_rdy;
    logic core_xfer;
    logic cop_xfer;
    logic [4:0]  xaddr;
    logic [31:0] xdata;

    always_comb begin
        at_lim    = (starve_q == LIM);
        core_rdy  = !rst && !(bus.cop_wb_valid && at_lim);
        cop_rdy   = !rst && (!bus.core_wb_valid || at_lim);
        core_xfer = bus.core_wb_valid && core_rdy;
        cop_xfer  = bus.cop_wb_valid && cop_rdy && !core_xfer;
        xaddr     = cop_xfer ? bus.cop_wb_addr : bus.core_wb_addr;
        xdata     = cop_xfer ? bus.cop_wb_data : bus.core_wb_data;
    end

    always_comb begin
        starve_d = starve_q;
        if (cop_xfer || !bus.cop_wb_valid) begin
            starve_d = '0;
        end else if (core_xfer && !at_lim) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // addr/data follow every transfer; x0 only suppresses the enable
    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (core_xfer || cop_xfer) begin
            wen_d   = (xaddr != 5'd0);
            waddr_d = xaddr;
            wdata_d = xdata;
        end
    end

    // clear first so a same-edge issue to that register keeps it pending
    always_comb begin
        busy_d = busy_q;
        if (cop_xfer) begin
            busy_d[bus.cop_wb_addr] = 1'b0;
        end
        if (bus.cop_issue_valid && bus.cop_issue_addr != 5'd0) begin
            busy_d[bus.cop_issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= 5'd0;
            wdata_q  <= 32'd0;
            busy_q   <= 32'd0;
        end else begin
            starve_q <= starve_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        bus.core_wb_ready = core_rdy;
        bus.cop_wb_ready  = cop_rdy;
        bus.rf_w_enable   = wen_q;
        bus.rf_rd_addr    = waddr_q;
        bus.rf_rd_data    = wdata_q;
        bus.busy_mask     = busy_q;
        bus.stall = (bus.rs1_addr != 5'd0 && busy_q[bus.rs1_addr]) ||
                    (bus.rs2_addr != 5'd0 && busy_q[bus.rs2_addr]);
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset sequence and
// randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;
    localparam int LIM = 3;

    logic clk;
    logic rst;
    regfile_wb_arbiter_if bif ();

    regfile_wb_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] cv, ca, cd, pv, pa, pd, iv, ia, r1, r2;
        logic [31:0] ecr, epr, est, ewen, chkrd, ea, ed, eb;
    } vec_t;

    vec_t tbl[19];

    task automatic drive(logic cv, logic [4:0] ca, logic [31:0] cd,
                         logic pv, logic [4:0] pa, logic [31:0] pd,
                         logic iv, logic [4:0] ia,
                         logic [4:0] r1, logic [4:0] r2);
        bif.core_wb_valid   = cv;
        bif.core_wb_addr    = ca;
        bif.core_wb_data    = cd;
        bif.cop_wb_valid    = pv;
        bif.cop_wb_addr     = pa;
        bif.cop_wb_data     = pd;
        bif.cop_issue_valid = iv;
        bif.cop_issue_addr  = ia;
        bif.rs1_addr        = r1;
        bif.rs2_addr        = r2;
    endtask

    // behavioural model state
    bit          m_busy[32];
    int          m_den;
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          m_known;

    function automatic logic [31:0] m_mask();
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = m_busy[i];
        return r;
    endfunction

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 0;
        m_den   = 0;
        m_wen   = 1'b0;
        m_addr  = 5'd0;
        m_data  = 32'd0;
        m_known = 1;
    endtask

    initial begin
        // cv ca cd pv pa pd iv ia r1 r2 | cr pr st | wen chk addr data busy
        tbl[0]  = '{1,3,'hDEADBEEF,0,0,0,0,0,0,0, 1,0,0, 1,1,3,'hDEADBEEF,0};
        tbl[1]  = '{0,0,0,0,0,0,0,0,0,0, 1,1,0, 0,1,3,'hDEADBEEF,0};
        tbl[2]  = '{1,5,'h11111111,1,10,'h12345678,0,0,0,0, 1,0,0, 1,1,5,'h11111111,0};
        tbl[3]  = '{1,5,'h11111111,1,10,'h12345678,0,0,0,0, 1,0,0, 1,1,5,'h11111111,0};
        tbl[4]  = '{1,5,'h11111111,1,10,'h12345678,0,0,0,0, 1,0,0, 1,1,5,'h11111111,0};
        tbl[5]  = '{1,5,'h11111111,1,10,'h12345678,0,0,0,0, 0,1,0, 1,1,10,'h12345678,0};
        tbl[6]  = '{1,5,'h11111111,1,10,'h12345678,0,0,0,0, 1,0,0, 1,1,5,'h11111111,0};
        tbl[7]  = '{0,0,0,0,0,0,0,0,0,0, 1,1,0, 0,1,5,'h11111111,0};
        tbl[8]  = '{0,0,0,0,0,0,1,7,7,0, 1,1,0, 0,1,5,'h11111111,'h80};
        tbl[9]  = '{0,0,0,0,0,0,1,7,7,0, 1,1,1, 0,1,5,'h11111111,'h80};
        tbl[10] = '{0,0,0,1,7,'hCAFEF00D,0,0,7,0, 1,1,1, 1,1,7,'hCAFEF00D,0};
        tbl[11] = '{0,0,0,0,0,0,0,0,7,0, 1,1,0, 0,1,7,'hCAFEF00D,0};
        tbl[12] = '{1,0,'hFFFFFFFF,0,0,0,0,0,0,0, 1,0,0, 0,0,0,0,0};
        tbl[13] = '{0,0,0,0,0,0,1,0,0,0, 1,1,0, 0,0,0,0,0};
        tbl[14] = '{0,0,0,0,0,0,1,9,0,9, 1,1,0, 0,0,0,0,'h200};
        tbl[15] = '{0,0,0,1,9,'h99,1,9,0,9, 1,1,1, 1,1,9,'h99,'h200};
        tbl[16] = '{1,9,'h55,0,0,0,0,0,0,9, 1,0,1, 1,1,9,'h55,'h200};
        tbl[17] = '{0,0,0,1,9,'h66,1,7,0,0, 1,1,0, 1,1,9,'h66,'h80};
        tbl[18] = '{0,0,0,0,0,0,1,10,0,0, 1,1,0, 0,1,9,'h66,'h480};

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_wen", 32'(bif.rf_w_enable), 0);
        chk("rst_addr", 32'(bif.rf_rd_addr), 0);
        chk("rst_data", bif.rf_rd_data, 0);
        chk("rst_busy", bif.busy_mask, 0);
        chk("rst_cop_rdy", 32'(bif.cop_wb_ready), 0);
        chk("rst_core_rdy", 32'(bif.core_wb_ready), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].cv[0], 5'(tbl[i].ca), tbl[i].cd,
                  tbl[i].pv[0], 5'(tbl[i].pa), tbl[i].pd,
                  tbl[i].iv[0], 5'(tbl[i].ia),
                  5'(tbl[i].r1), 5'(tbl[i].r2));
            #1;
            chk($sformatf("v%0d_core_rdy", i), 32'(bif.core_wb_ready), tbl[i].ecr);
            chk($sformatf("v%0d_cop_rdy", i), 32'(bif.cop_wb_ready), tbl[i].epr);
            chk($sformatf("v%0d_stall", i), 32'(bif.stall), tbl[i].est);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wen", i), 32'(bif.rf_w_enable), tbl[i].ewen);
            chk($sformatf("v%0d_busy", i), bif.busy_mask, tbl[i].eb);
            if (tbl[i].chkrd[0]) begin
                chk($sformatf("v%0d_addr", i), 32'(bif.rf_rd_addr), tbl[i].ea);
                chk($sformatf("v%0d_data", i), bif.rf_rd_data, tbl[i].ed);
            end
            @(negedge clk);
        end

        // reset with bits 7,10 pending and transfers presented in the reset cycle
        chk("pre_rst_busy", bif.busy_mask, 32'h480);
        drive(1, 3, 32'hAAAA5555, 1, 10, 32'h5555AAAA, 1, 11, 7, 10);
        rst = 1'b1;
        #1;
        chk("midrst_core_rdy", 32'(bif.core_wb_ready), 0);
        chk("midrst_cop_rdy", 32'(bif.cop_wb_ready), 0);
        @(posedge clk);
        #1;
        chk("midrst_busy", bif.busy_mask, 0);
        chk("midrst_wen", 32'(bif.rf_w_enable), 0);
        chk("midrst_addr", 32'(bif.rf_rd_addr), 0);
        chk("midrst_stall", 32'(bif.stall), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("postrst_wen", 32'(bif.rf_w_enable), 0);
        @(negedge clk);

        // randomized traffic against the model
        model_reset();
        for (int c = 0; c < 600; c++) begin
            logic cv, pv, iv, r;
            logic [4:0] ca, pa, ia, r1, r2;
            logic [31:0] cd, pd;
            logic ecr, epr, est;
            int win;
            cv = ($urandom_range(0, 99) < 60);
            pv = ($urandom_range(0, 99) < 60);
            iv = ($urandom_range(0, 99) < 30);
            ca = 5'($urandom_range(0, 11));
            pa = 5'($urandom_range(0, 11));
            ia = 5'($urandom_range(0, 11));
            r1 = 5'($urandom_range(0, 11));
            r2 = 5'($urandom_range(0, 11));
            cd = $urandom;
            pd = $urandom;
            r  = ($urandom_range(0, 99) < 2);
            drive(cv, ca, cd, pv, pa, pd, iv, ia, r1, r2);
            rst = r;
            #1;
            ecr = !r && !(pv && m_den == LIM);
            epr = !r && (!cv || m_den == LIM);
            est = (r1 != 0 && m_busy[r1]) || (r2 != 0 && m_busy[r2]);
            chk("rnd_core_rdy", 32'(bif.core_wb_ready), 32'(ecr));
            chk("rnd_cop_rdy", 32'(bif.cop_wb_ready), 32'(epr));
            chk("rnd_stall", 32'(bif.stall), 32'(est));

            // 0 none, 1 core, 2 coprocessor
            if (cv && pv) win = (m_den == LIM) ? 2 : 1;
            else if (cv) win = 1;
            else if (pv) win = 2;
            else win = 0;

            if (r) begin
                model_reset();
            end else begin
                if (win == 2 || !pv) m_den = 0;
                else if (m_den < LIM) m_den++;
                m_wen = 1'b0;
                if (win != 0) begin
                    logic [4:0] a;
                    a = (win == 1) ? ca : pa;
                    m_wen = (a != 0);
                    if (a != 0) begin
                        m_addr  = a;
                        m_data  = (win == 1) ? cd : pd;
                        m_known = 1;
                    end else begin
                        m_known = 0;
                    end
                end
                if (win == 2) m_busy[pa] = 0;
                if (iv && ia != 0) m_busy[ia] = 1;
            end

            @(posedge clk);
            #1;
            chk("rnd_wen", 32'(bif.rf_w_enable), 32'(m_wen));
            chk("rnd_busy", bif.busy_mask, m_mask());
            if (m_known) begin
                chk("rnd_addr", 32'(bif.rf_rd_addr), 32'(m_addr));
                chk("rnd_data", bif.rf_rd_data, m_data);
            end
            @(negedge clk);
        end

        rst = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
